memory_arbiter: RTL and testbench

Two-port arbiter that shares the single-port-per-direction `memory` block (256 x 8, combinational read, write-enable driven store) between two requesters, e.g. the CPU load/store unit (requester 0) and the program loader/debug port (requester 1). It accepts one transaction per cycle with a valid/ready handshake and round-robin fairness, and registers read data back to the winner one cycle later. After reset it runs a one-cycle clear sequence that zeroes the memory through its `reset` input.

---
 rtl/memory_arbiter_pkg.sv | 19 +
 rtl/memory_arbiter_rr_pick2.sv | 27 ++
 rtl/memory_arbiter.sv | 131 +++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// memory_arbiter_pkg
// Shared encodings and defaults for the two-requester memory arbiter.
// Revision: 1.0
// ============================================================================
package memory_arbiter_pkg;

    localparam int NUM_REQ            = 2;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_LINE_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_t;

endpackage : memory_arbiter_pkg
`default_nettype wire

// File: rtl/memory_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2
// Combinational two-way round-robin picker producing a one-hot (or zero) grant.
// Revision: 1.0
// ============================================================================
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] w_cand;

    assign w_cand = valid & mask;

    always_comb begin
        grant = w_cand;
        // On a tie the requester that did not win last time goes first.
        if (w_cand == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter
// Round-robin valid/ready arbiter sharing one memory between two requesters,
// with a one-cycle memory clear after reset.
// Optional grant locking is enabled by defining MEMORY_ARBITER_LOCK_EN.
// Revision: 1.0
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
`ifdef MEMORY_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*LINE_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_read_address,
    output logic [ADDR_WIDTH-1:0]         mem_write_address,
    output logic [LINE_WIDTH-1:0]         mem_write_data,
    output logic                          mem_write_enable,
    output logic                          mem_reset,
    input  logic [LINE_WIDTH-1:0]         mem_read_data
);

    arb_state_t                  r_state;
    logic                        r_last;
    logic [NUM_REQ-1:0]          r_rsp_valid;
    logic [NUM_REQ*LINE_WIDTH-1:0] r_rsp_rdata;

    logic [ADDR_WIDTH-1:0]       w_addr  [NUM_REQ];
    logic [LINE_WIDTH-1:0]       w_wdata [NUM_REQ];
    logic                        w_run;
    logic [NUM_REQ-1:0]          w_mask;
    logic [NUM_REQ-1:0]          w_grant;
    logic                        w_accept;
    logic                        w_gnt_idx;
    logic                        w_gnt_write;
    logic [ADDR_WIDTH-1:0]       w_sel_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = req_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
        end
    endgenerate

    // Nothing may be granted while reset is held or the clear cycle runs.
    assign w_run = reset_n && (r_state == ST_RUN);

`ifdef MEMORY_ARBITER_LOCK_EN
    logic r_locked;
    logic r_owner;

    assign w_mask = !w_run   ? 2'b00 :
                    r_locked ? (r_owner ? 2'b10 : 2'b01) :
                               2'b11;
`else
    assign w_mask = w_run ? 2'b11 : 2'b00;
`endif

    rr_pick2 u_pick (
        .valid (req_valid),
        .last  (r_last),
        .mask  (w_mask),
        .grant (w_grant)
    );

    assign w_accept    = |w_grant;
    assign w_gnt_idx   = w_grant[1];
    assign w_gnt_write = req_write[w_gnt_idx];
    assign w_sel_addr  = w_addr[w_gnt_idx];

    assign req_ready         = w_grant;
    assign mem_read_address  = w_sel_addr;
    assign mem_write_address = w_sel_addr;
    assign mem_write_data    = w_wdata[w_gnt_idx];
    assign mem_write_enable  = w_accept && w_gnt_write;
    assign mem_reset         = !reset_n || (r_state == ST_CLEAR);

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_CLEAR;
            r_last      <= 1'b1;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
`ifdef MEMORY_ARBITER_LOCK_EN
            r_locked    <= 1'b0;
            r_owner     <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                ST_CLEAR: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_last <= w_gnt_idx;
                        if (!w_gnt_write) begin
                            r_rsp_valid[w_gnt_idx] <= 1'b1;
                            r_rsp_rdata[w_gnt_idx*LINE_WIDTH +: LINE_WIDTH] <= mem_read_data;
                        end
`ifdef MEMORY_ARBITER_LOCK_EN
                        r_locked <= req_lock[w_gnt_idx];
                        r_owner  <= w_gnt_idx;
`endif
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule : memory_arbiter
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_memory_arbiter
// Directed and random stimulus against a transaction-level arbiter/memory model.
// Revision: 1.0
// ============================================================================
module tb_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_address;
    logic [15:0] req_wdata;
    logic [1:0]  req_lock;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  mem_read_address;
    logic [7:0]  mem_write_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic        mem_reset;
    logic [7:0]  mem_read_data;

    memory_arbiter #(.ADDR_WIDTH(8), .LINE_WIDTH(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_wdata         (req_wdata),
`ifdef MEMORY_ARBITER_LOCK_EN
        .req_lock          (req_lock),
`endif
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_enable  (mem_write_enable),
        .mem_reset         (mem_reset),
        .mem_read_data     (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: combinational read, clear and write on the clock edge.
    logic [7:0] mem [256];
    assign mem_read_data = mem[mem_read_address];
    always @(posedge clk) begin
        if (mem_reset) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
        end else if (mem_write_enable) begin
            mem[mem_write_address] <= mem_write_data;
        end
    end

    int         checks;
    int         errors;
    logic [7:0] ref_mem [256];
    bit         m_run;
    bit         m_last;
    logic [1:0] m_rsp_valid;
    logic [7:0] m_rdata [2];
    bit         m_locked;
    bit         m_owner;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_ready();
        logic [1:0] elig;
        logic [1:0] cand;
        if (!reset_n || !m_run) return 2'b00;
        elig = m_locked ? (m_owner ? 2'b10 : 2'b01) : 2'b11;
        cand = req_valid & elig;
        if (cand == 2'b11) return m_last ? 2'b01 : 2'b10;
        return cand;
    endfunction

    task automatic set_req(input int i, input bit v, input bit w, input logic [7:0] a,
                           input logic [7:0] d, input bit lk);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_address[i*8 +: 8] = a;
        req_wdata[i*8 +: 8]   = d;
        req_lock[i]          = lk;
    endtask

    task automatic step();
        logic [1:0] er;
        int         g;
        logic [7:0] a;
        logic [7:0] d;
        bit         wr;
        @(negedge clk);
        er = exp_ready();
        g  = er[1] ? 1 : 0;
        a  = req_address[g*8 +: 8];
        d  = req_wdata[g*8 +: 8];
        wr = req_write[g];
        chk("req_ready", {14'd0, req_ready}, {14'd0, er});
        chk("mem_reset", {15'd0, mem_reset}, {15'd0, (!reset_n || !m_run)});
        chk("mem_write_enable", {15'd0, mem_write_enable}, {15'd0, (er != 2'b00) && wr});
        if (er != 2'b00) begin
            chk("mem_read_address", {8'd0, mem_read_address}, {8'd0, a});
            if (wr) begin
                chk("mem_write_address", {8'd0, mem_write_address}, {8'd0, a});
                chk("mem_write_data", {8'd0, mem_write_data}, {8'd0, d});
            end
        end
        chk("rsp_valid", {14'd0, rsp_valid}, {14'd0, m_rsp_valid});
        chk("rsp_rdata0", {8'd0, rsp_rdata[7:0]}, {8'd0, m_rdata[0]});
        chk("rsp_rdata1", {8'd0, rsp_rdata[15:8]}, {8'd0, m_rdata[1]});
        @(posedge clk);
        m_rsp_valid = 2'b00;
        if (!reset_n) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
            m_run = 0; m_last = 1; m_rdata[0] = 0; m_rdata[1] = 0;
            m_locked = 0; m_owner = 0;
        end else if (!m_run) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
            m_run = 1;
        end else if (er != 2'b00) begin
            if (wr) begin
                ref_mem[a] = d;
            end else begin
                m_rsp_valid[g] = 1'b1;
                m_rdata[g]     = ref_mem[a];
            end
            m_last = (g == 1);
`ifdef MEMORY_ARBITER_LOCK_EN
            m_locked = req_lock[g];
            m_owner  = (g == 1);
`endif
        end
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_run = 0; m_last = 1; m_rsp_valid = 0; m_rdata[0] = 0; m_rdata[1] = 0;
        m_locked = 0; m_owner = 0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
        reset_n = 1'b0;
        req_valid = 0; req_write = 0; req_address = 0; req_wdata = 0; req_lock = 0;
        repeat (2) @(posedge clk);
        #1;
        // Held in reset with traffic offered: nothing may be granted.
        set_req(0, 1, 1, 8'h44, 8'h99, 0);
        step(); step();

        // Release: one clear cycle, then reads of 0x00 / 0xFF see zero.
        reset_n = 1'b1;
        set_req(0, 1, 0, 8'h00, 8'h00, 0);
        set_req(1, 1, 0, 8'hFF, 8'h00, 0);
        step(); step(); step();
        set_req(0, 0, 0, 8'h00, 8'h00, 0);
        set_req(1, 0, 0, 8'h00, 8'h00, 0);
        step();

        // Write then read-after-write from the other requester.
        set_req(0, 1, 1, 8'h10, 8'h5A, 0);
        step();
        set_req(0, 0, 0, 8'h00, 8'h00, 0);
        set_req(1, 1, 0, 8'h10, 8'h00, 0);
        step();
        set_req(1, 0, 0, 8'h00, 8'h00, 0);
        step();

        // Continuous contention must alternate.
        set_req(0, 1, 0, 8'h01, 8'h00, 0);
        set_req(1, 1, 0, 8'h02, 8'h00, 0);
        repeat (8) step();

        // Reset lands on an offered write: the write is dropped.
        set_req(0, 1, 1, 8'h20, 8'h33, 0);
        set_req(1, 0, 0, 8'h00, 8'h00, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        set_req(0, 0, 0, 8'h00, 8'h00, 0);
        step();
        set_req(1, 1, 0, 8'h20, 8'h00, 0);
        step();
        set_req(1, 0, 0, 8'h00, 8'h00, 0);
        step();

`ifdef MEMORY_ARBITER_LOCK_EN
        // Requester 0 locks; requester 1 waits until the unlocking transfer.
        set_req(0, 1, 0, 8'h10, 8'h00, 1);
        set_req(1, 1, 0, 8'h11, 8'h00, 0);
        step();
        set_req(0, 0, 0, 8'h00, 8'h00, 0);
        repeat (3) step();
        set_req(0, 1, 0, 8'h12, 8'h00, 0);
        step();
        set_req(0, 0, 0, 8'h00, 8'h00, 0);
        step(); step();
        set_req(1, 0, 0, 8'h00, 8'h00, 0);
`endif

        // Random traffic on a small address window so reads hit earlier writes.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                        8'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 4) == 0));
            end
            reset_n = ($urandom_range(0, 60) != 0);
            step();
        end
        reset_n = 1'b1;
        req_valid = 0;
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_memory_arbiter
`default_nettype wire
